phase_acc: RTL and testbench
============================

PHASE_ACC -- requirements
Module: phase_acc

Interface
REQ-001 Parameter ACC_W, default 32, width of phase, frequency and shift words; all ACC_W ports are sized by it.
REQ-002 clk  in  1  system clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 freq  in  ACC_W  unsigned phase increment per clk (2^ACC_W = 360 deg).
REQ-005 freq_load  in  1  one-clk strobe; capture freq into the working increment register f_reg.
REQ-006 freq_add  in  ACC_W  signed two's-complement frequency correction from the phase adjuster.
REQ-007 adj_active  in  1  adjuster active; freq_add valid while 1.
REQ-008 adj_ready  in  1  adjuster end-of-run pulse.
REQ-009 sync_clr  in  1  one-clk strobe; force phase to 0.
REQ-010 snap_req  in  1  one-clk strobe; request phase snapshot.
REQ-011 phase  out  ACC_W  running phase accumulator.
REQ-012 shift_acc  out  ACC_W  signed integral of freq_add over the current/last adjust window.
REQ-013 snap_phase  out  ACC_W  captured phase; snap_valid  out  1  one-clk pulse when snap_phase is updated.
REQ-014 busy  out  1  high in ADJ; done  out  1  one-clk pulse in DONE.

Function
REQ-015 f_reg <= freq on the edge where freq_load=1; the new value is used from the following edge.
REQ-016 Every edge: phase <= phase + f_reg + (adj_active ? freq_add : 0), modulo 2^ACC_W, wrap silent.
REQ-017 sync_clr=1 sets phase to 0 on that edge, overriding REQ-016; simultaneous freq_load is still honoured.
REQ-018 FSM states IDLE, ADJ, DONE; reset state IDLE.
REQ-019 IDLE -> ADJ when adj_active=1; on that edge shift_acc <= freq_add (restart integral).
REQ-020 ADJ: shift_acc <= shift_acc + freq_add each edge while adj_active=1, modulo 2^ACC_W.
REQ-021 ADJ -> DONE when adj_ready=1 or adj_active=0; the sample on that edge is accumulated only if adj_active=1.
REQ-022 DONE -> IDLE unconditionally next edge; done=1 only in DONE; shift_acc holds until next ADJ entry.
REQ-023 busy=1 exactly when state is ADJ.
REQ-024 snap_req=1 on edge n: snap_phase <= phase value present before edge n; snap_valid=1 for the cycle after edge n; back-to-back requests each yield one pulse.
REQ-025 snap_req coincident with sync_clr captures the pre-clear phase.

Reset
REQ-026 reset=1 on an edge: phase, f_reg, shift_acc, snap_phase = 0; snap_valid, busy, done = 0; state IDLE; overrides all inputs.
REQ-027 reset during ADJ aborts the window without a done pulse.

Configuration
REQ-028 Macro PHASE_ACC_SNAP_EN defined: snapshot logic per REQ-024/025 present.
REQ-029 Macro undefined: snap_req ignored, snap_phase and snap_valid tied 0, no snapshot registers.

Structure
REQ-030 Shared package holds the FSM state enum (IDLE/ADJ/DONE) and default ACC_W constant.
REQ-031 Single module, no sub-modules; one adder chain for phase, one for shift_acc.

Verification
REQ-032 reset; freq=0x0147AE14 with freq_load at edge 0 -> phase=0x0147AE14, 0x028F5C28, 0x03D70A3C after edges 1,2,3.
REQ-033 phase=0xFFFFFF00, f_reg=0x200 -> phase=0x00000100 next edge (wrap).
REQ-034 adj_active high 4 edges, freq_add=0x100, then adj_ready -> busy 4 cycles, shift_acc=0x400, done one pulse, phase exceeds baseline by 0x400.
REQ-035 freq_add=0xFFFFFF00 for 2 edges -> shift_acc=0xFFFFFE00, phase lags baseline by 0x200.
REQ-036 snap_req with phase=0x12345678 and sync_clr same edge -> snap_phase=0x12345678, snap_valid one pulse, phase=0 (only with PHASE_ACC_SNAP_EN; without it snap_valid stays 0).
REQ-037 reset asserted mid-ADJ -> all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/phase_acc_pkg.sv
// Shared types and defaults for the phase accumulator.
package phase_acc_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADJ  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with adjust-window frequency correction and optional snapshot.
// Snapshot logic is built only when PHASE_ACC_SNAP_EN is defined.
module phase_acc
  import phase_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] freq,
  input  logic             freq_load,
  input  logic [ACC_W-1:0] freq_add,
  input  logic             adj_active,
  input  logic             adj_ready,
  input  logic             sync_clr,
  input  logic             snap_req,
  output logic [ACC_W-1:0] phase,
  output logic [ACC_W-1:0] shift_acc,
  output logic [ACC_W-1:0] snap_phase,
  output logic             snap_valid,
  output logic             busy,
  output logic             done
);

  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] f_reg_q, f_reg_d;
  logic [ACC_W-1:0] shift_acc_q, shift_acc_d;
  logic [ACC_W-1:0] add_term;
  state_e           state_q, state_d;

  always_comb begin
    f_reg_d  = freq_load ? freq : f_reg_q;
    add_term = adj_active ? freq_add : '0;
    // Clear wins over the increment; f_reg load is independent of it.
    phase_d  = sync_clr ? '0 : (phase_q + f_reg_q + add_term);
  end

  always_comb begin
    state_d     = state_q;
    shift_acc_d = shift_acc_q;
    case (state_q)
      IDLE: begin
        if (adj_active) begin
          state_d     = ADJ;
          shift_acc_d = freq_add;
        end
      end
      ADJ: begin
        shift_acc_d = shift_acc_q + add_term;
        if (adj_ready || !adj_active) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      f_reg_q     <= '0;
      shift_acc_q <= '0;
      state_q     <= IDLE;
    end else begin
      phase_q     <= phase_d;
      f_reg_q     <= f_reg_d;
      shift_acc_q <= shift_acc_d;
      state_q     <= state_d;
    end
  end

  assign phase     = phase_q;
  assign shift_acc = shift_acc_q;
  assign busy      = (state_q == ADJ);
  assign done      = (state_q == DONE);

`ifdef PHASE_ACC_SNAP_EN
  logic [ACC_W-1:0] snap_phase_q, snap_phase_d;
  logic             snap_valid_q, snap_valid_d;

  // Captures the pre-edge phase, so a coincident sync_clr does not affect it.
  always_comb begin
    snap_phase_d = snap_req ? phase_q : snap_phase_q;
    snap_valid_d = snap_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_phase_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_phase_q <= snap_phase_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_phase = snap_phase_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_snap_req;
  assign unused_snap_req = snap_req;
  assign snap_phase      = '0;
  assign snap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_phase_acc.sv
// Directed self-checking bench for phase_acc; snapshot checks follow PHASE_ACC_SNAP_EN.
module tb_phase_acc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] freq;
  logic         freq_load;
  logic [W-1:0] freq_add;
  logic         adj_active;
  logic         adj_ready;
  logic         sync_clr;
  logic         snap_req;
  logic [W-1:0] phase;
  logic [W-1:0] shift_acc;
  logic [W-1:0] snap_phase;
  logic         snap_valid;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  phase_acc #(.ACC_W(W)) dut (
    .clk(clk), .reset(reset), .freq(freq), .freq_load(freq_load),
    .freq_add(freq_add), .adj_active(adj_active), .adj_ready(adj_ready),
    .sync_clr(sync_clr), .snap_req(snap_req), .phase(phase),
    .shift_acc(shift_acc), .snap_phase(snap_phase), .snap_valid(snap_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; freq = '0; freq_load = 0; freq_add = '0;
    adj_active = 0; adj_ready = 0; sync_clr = 0; snap_req = 0;
  endtask

  // Clears phase and loads a new increment on the same edge.
  task automatic clear_and_load(input logic [W-1:0] f);
    idle_inputs();
    sync_clr = 1; freq_load = 1; freq = f;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; freq_load = 1; freq = 32'hABC; adj_active = 1;
    freq_add = 32'h5; snap_req = 1;
    tick();
    tick();
    checks++; if (phase !== '0) begin failures++; $display("FAIL reset_phase got=%h exp=0", phase); end
    checks++; if (shift_acc !== '0) begin failures++; $display("FAIL reset_shift got=%h exp=0", shift_acc); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_fsm busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (snap_valid !== 1'b0 || snap_phase !== '0) begin failures++; $display("FAIL reset_snap valid=%b phase=%h exp=0/0", snap_valid, snap_phase); end
    idle_inputs();
    tick();
    checks++; if (phase !== '0) begin failures++; $display("FAIL reset_freg got=%h exp=0", phase); end
  endtask

  task automatic test_freq_load();
    logic [W-1:0] exp_ph [3];
    exp_ph[0] = 32'h0147AE14; exp_ph[1] = 32'h028F5C28; exp_ph[2] = 32'h03D70A3C;
    idle_inputs();
    freq = 32'h0147AE14; freq_load = 1;
    tick();
    idle_inputs();
    checks++; if (phase !== '0) begin failures++; $display("FAIL load_edge0 got=%h exp=0", phase); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (phase !== exp_ph[i]) begin failures++; $display("FAIL load_edge%0d got=%h exp=%h", i + 1, phase, exp_ph[i]); end
    end
  endtask

  task automatic test_wrap();
    clear_and_load(32'hFFFFFF00);
    freq_load = 1; freq = 32'h200;
    tick();
    idle_inputs();
    checks++; if (phase !== 32'hFFFFFF00) begin failures++; $display("FAIL wrap_pre got=%h exp=ffffff00", phase); end
    tick();
    checks++; if (phase !== 32'h00000100) begin failures++; $display("FAIL wrap_post got=%h exp=00000100", phase); end
  endtask

  task automatic test_adjust_pos();
    int busy_cnt = 0;
    int done_cnt = 0;
    clear_and_load(32'h10);
    adj_active = 1; freq_add = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    checks++; if (phase !== 32'h440) begin failures++; $display("FAIL adjp_phase got=%h exp=440", phase); end
    adj_active = 0; adj_ready = 1; freq_add = '0;
    tick();
    idle_inputs();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL adjp_done done=%b busy=%b exp=1/0", done, busy); end
    checks++; if (shift_acc !== 32'h400) begin failures++; $display("FAIL adjp_shift got=%h exp=400", shift_acc); end
    if (done) done_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    checks++; if (busy_cnt != 4) begin failures++; $display("FAIL adjp_busy_cycles got=%0d exp=4", busy_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL adjp_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (shift_acc !== 32'h400) begin failures++; $display("FAIL adjp_shift_hold got=%h exp=400", shift_acc); end
    checks++; if (phase !== 32'h480) begin failures++; $display("FAIL adjp_phase_end got=%h exp=480", phase); end
  endtask

  task automatic test_adjust_neg();
    clear_and_load(32'h10);
    adj_active = 1; freq_add = 32'hFFFFFF00;
    tick();
    checks++; if (busy !== 1'b1 || shift_acc !== 32'hFFFFFF00) begin failures++; $display("FAIL adjn_entry busy=%b shift=%h exp=1/ffffff00", busy, shift_acc); end
    tick();
    idle_inputs();
    checks++; if (phase !== 32'hFFFFFE20) begin failures++; $display("FAIL adjn_phase got=%h exp=fffffe20", phase); end
    tick();
    checks++; if (shift_acc !== 32'hFFFFFE00 || done !== 1'b1) begin failures++; $display("FAIL adjn_shift got=%h done=%b exp=fffffe00/1", shift_acc, done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL adjn_idle done=%b busy=%b exp=0/0", done, busy); end
  endtask

  task automatic test_snapshot();
    clear_and_load(32'h12345678);
    freq_load = 1; freq = '0;
    tick();
    idle_inputs();
    checks++; if (phase !== 32'h12345678) begin failures++; $display("FAIL snap_setup got=%h exp=12345678", phase); end
    snap_req = 1; sync_clr = 1;
    tick();
    idle_inputs();
    checks++; if (phase !== '0) begin failures++; $display("FAIL snap_clr got=%h exp=0", phase); end
`ifdef PHASE_ACC_SNAP_EN
    checks++; if (snap_valid !== 1'b1 || snap_phase !== 32'h12345678) begin failures++; $display("FAIL snap_capture valid=%b got=%h exp=1/12345678", snap_valid, snap_phase); end
`else
    checks++; if (snap_valid !== 1'b0 || snap_phase !== '0) begin failures++; $display("FAIL snap_disabled valid=%b got=%h exp=0/0", snap_valid, snap_phase); end
`endif
    tick();
    checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL snap_pulse_end got=%b exp=0", snap_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_snap;
    logic         exp_v;
    freq_load = 1; freq = 32'h5;
    tick();
    snap_req = 1; freq_load = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_snap = 32'h5 * i;
`ifdef PHASE_ACC_SNAP_EN
      exp_v = 1'b1;
`else
      exp_v = 1'b0; exp_snap = '0;
`endif
      checks++; if (snap_valid !== exp_v || snap_phase !== exp_snap) begin failures++; $display("FAIL b2b_snap%0d valid=%b got=%h exp=%b/%h", i, snap_valid, snap_phase, exp_v, exp_snap); end
    end
    idle_inputs();
    tick();
    checks++; if (snap_valid !== 1'b0 || phase !== 32'hF) begin failures++; $display("FAIL b2b_end valid=%b phase=%h exp=0/f", snap_valid, phase); end
  endtask

  task automatic test_reset_mid_adj();
    int done_cnt = 0;
    clear_and_load(32'h10);
    adj_active = 1; freq_add = 32'h7;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rma_busy got=%b exp=1", busy); end
    reset = 1; adj_ready = 1; snap_req = 1;
    tick();
    checks++; if (phase !== '0 || shift_acc !== '0 || busy !== 1'b0 || done !== 1'b0 || snap_valid !== 1'b0 || snap_phase !== '0) begin
      failures++; $display("FAIL rma_outputs phase=%h shift=%h busy=%b done=%b sv=%b sp=%h exp=all0", phase, shift_acc, busy, done, snap_valid, snap_phase);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rma_no_done got=%0d exp=0", done_cnt); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_freq_load();
    test_wrap();
    test_adjust_pos();
    test_adjust_neg();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_adj();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
